// File: rtl/manycore_eva_xlate.sv
// Combinational EVA -> NPA translation for the tile network-tx path.
// Decodes DRAM, global and tile-group regions by priority; local EVAs are flagged invalid.
module manycore_eva_xlate #(
  parameter int data_width_p                 = 32,
  parameter int addr_width_p                 = 28,
  parameter int x_cord_width_p               = 7,
  parameter int y_cord_width_p               = 7,
  parameter int pod_x_cord_width_p           = 3,
  parameter int pod_y_cord_width_p           = 4,
  parameter int num_tiles_x_p                = 16,
  parameter int num_tiles_y_p                = 8,
  parameter int vcache_block_size_in_words_p = 8,
  parameter int vcache_sets_p                = 64,
  parameter int vcache_size_p                = 4096,
  parameter int ipoly_hashing_p              = 0,
  localparam int XS = $clog2(num_tiles_x_p),
  localparam int YS = $clog2(num_tiles_y_p)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [31:0]                   eva_i,
  input  logic [XS-1:0]                 tgo_x_i,
  input  logic [YS-1:0]                 tgo_y_i,
  input  logic [pod_x_cord_width_p-1:0] pod_x_i,
  input  logic [pod_y_cord_width_p-1:0] pod_y_i,
  output logic [x_cord_width_p-1:0]     x_cord_o,
  output logic [y_cord_width_p-1:0]     y_cord_o,
  output logic [addr_width_p-1:0]       epa_o,
  output logic                          is_invalid_addr_o
);

  localparam int W = $clog2(vcache_block_size_in_words_p);
  localparam int B = 2 + W;
  localparam int L = $clog2(2 * num_tiles_x_p);
  localparam int E = 30 - x_cord_width_p - y_cord_width_p;
  localparam int T = 29 - XS - YS;

  localparam logic [pod_y_cord_width_p-1:0] pod_y_one = 1;

  if (data_width_p != 32) begin : g_chk_data_width
    $error("manycore_eva_xlate: data_width_p must be 32");
  end
  if (x_cord_width_p != pod_x_cord_width_p + XS) begin : g_chk_x_width
    $error("manycore_eva_xlate: x_cord_width_p must equal pod_x_cord_width_p + XS");
  end
  if (y_cord_width_p != pod_y_cord_width_p + YS) begin : g_chk_y_width
    $error("manycore_eva_xlate: y_cord_width_p must equal pod_y_cord_width_p + YS");
  end
  if ((1 << XS) != num_tiles_x_p) begin : g_chk_tiles_x_pow2
    $error("manycore_eva_xlate: num_tiles_x_p must be a power of 2");
  end
  if (addr_width_p > 32) begin : g_chk_addr_width
    $error("manycore_eva_xlate: addr_width_p must not exceed 32");
  end

  // ---------------- DRAM region ----------------
  logic [L-1:0]                  bank_raw;
  logic [L-1:0]                  bank;
  logic                          dram_south;
  logic [pod_y_cord_width_p-1:0] pod_y_south;
  logic [pod_y_cord_width_p-1:0] pod_y_north;
  logic [x_cord_width_p-1:0]     dram_x;
  logic [y_cord_width_p-1:0]     dram_y;
  logic [31:0]                   dram_epa_hi;
  logic [31:0]                   dram_epa_lo;
  logic [31:0]                   dram_epa_full;

  assign bank_raw = eva_i[B +: L];

  if (ipoly_hashing_p != 0) begin : g_ipoly
    assign bank = bank_raw ^ eva_i[B+L +: L];
  end else begin : g_no_ipoly
    assign bank = bank_raw;
  end

  // The top bank bit selects the vcache row below (south) or above (north) the pod.
  assign dram_south  = bank[L-1];
  assign pod_y_south = pod_y_i + pod_y_one;
  assign pod_y_north = pod_y_i - pod_y_one;
  assign dram_x      = {pod_x_i, bank[XS-1:0]};
  assign dram_y      = dram_south ? {pod_y_south, {YS{1'b0}}}
                                  : {pod_y_north, {YS{1'b1}}};

  // Bank bits are squeezed out of the word address: {eva[30:B+L], eva[B-1:2]}.
  assign dram_epa_hi   = ({1'b0, eva_i[30:0]} >> (B + L)) << (B - 2);
  assign dram_epa_lo   = (eva_i >> 2) & ((32'h1 << (B - 2)) - 32'h1);
  assign dram_epa_full = dram_epa_hi | dram_epa_lo;

  // ---------------- Global region ----------------
  logic [x_cord_width_p-1:0] global_x;
  logic [y_cord_width_p-1:0] global_y;
  logic [31:0]               global_epa_full;

  assign global_y        = eva_i[29 -: y_cord_width_p];
  assign global_x        = eva_i[E +: x_cord_width_p];
  assign global_epa_full = (eva_i & ((32'h1 << E) - 32'h1)) >> 2;

  // ---------------- Tile-group region ----------------
  logic [XS-1:0]             tg_xoff;
  logic [YS-1:0]             tg_yoff;
  logic [XS-1:0]             tg_xsub;
  logic [YS-1:0]             tg_ysub;
  logic [x_cord_width_p-1:0] tg_x;
  logic [y_cord_width_p-1:0] tg_y;
  logic [31:0]               tg_epa_full;

  assign tg_yoff     = eva_i[28 -: YS];
  assign tg_xoff     = eva_i[T +: XS];
  assign tg_xsub     = tgo_x_i + tg_xoff;
  assign tg_ysub     = tgo_y_i + tg_yoff;
  assign tg_x        = {pod_x_i, tg_xsub};
  assign tg_y        = {pod_y_i, tg_ysub};
  assign tg_epa_full = (eva_i & ((32'h1 << T) - 32'h1)) >> 2;

  // ---------------- Priority select ----------------
  always_comb begin
    x_cord_o          = '0;
    y_cord_o          = '0;
    epa_o             = '0;
    is_invalid_addr_o = 1'b0;
    if (eva_i[31]) begin
      x_cord_o = dram_x;
      y_cord_o = dram_y;
      epa_o    = dram_epa_full[addr_width_p-1:0];
    end else if (eva_i[30]) begin
      x_cord_o = global_x;
      y_cord_o = global_y;
      epa_o    = global_epa_full[addr_width_p-1:0];
    end else if (eva_i[29]) begin
      x_cord_o = tg_x;
      y_cord_o = tg_y;
      epa_o    = tg_epa_full[addr_width_p-1:0];
    end else begin
      is_invalid_addr_o = 1'b1;
    end
  end

  // Invalid must track exactly the local region; local EVAs never drive a destination.
  a_invalid_local: assert property (@(posedge clk_i) disable iff (reset_i)
    is_invalid_addr_o == (eva_i[31:29] == 3'b000));
  a_local_zero: assert property (@(posedge clk_i) disable iff (reset_i)
    is_invalid_addr_o |-> (x_cord_o == '0 && y_cord_o == '0 && epa_o == '0));

endmodule

// File: tb/tb_manycore_eva_xlate.sv
// Directed bench for manycore_eva_xlate: driver pushes expected NPAs into a queue,
// a negedge monitor pops and compares against the combinational outputs.
module tb_manycore_eva_xlate;

  localparam int XW = 7;
  localparam int YW = 7;
  localparam int AW = 28;
  localparam int RW = 1 + XW + YW + AW;

  logic          clk;
  logic          reset;
  logic [31:0]   eva;
  logic [3:0]    tgo_x;
  logic [2:0]    tgo_y;
  logic [2:0]    pod_x;
  logic [3:0]    pod_y;
  logic [XW-1:0] x_cord;
  logic [YW-1:0] y_cord;
  logic [AW-1:0] epa;
  logic          is_invalid;

  logic [RW-1:0] exp_q[$];
  string         name_q[$];
  int            n_vectors;
  int            n_miscompares;

  manycore_eva_xlate dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .eva_i             (eva),
    .tgo_x_i           (tgo_x),
    .tgo_y_i           (tgo_y),
    .pod_x_i           (pod_x),
    .pod_y_i           (pod_y),
    .x_cord_o          (x_cord),
    .y_cord_o          (y_cord),
    .epa_o             (epa),
    .is_invalid_addr_o (is_invalid)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver ----------------
  task automatic apply(input string name, input logic rst, input logic [31:0] e,
                       input logic [3:0] tx, input logic [2:0] ty,
                       input logic [2:0] px, input logic [3:0] py,
                       input logic inv, input logic [XW-1:0] ex,
                       input logic [YW-1:0] ey, input logic [AW-1:0] ee);
    @(posedge clk);
    #1;
    reset = rst;
    eva   = e;
    tgo_x = tx;
    tgo_y = ty;
    pod_x = px;
    pod_y = py;
    exp_q.push_back({inv, ex, ey, ee});
    name_q.push_back(name);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [RW-1:0] exp_v;
      logic [RW-1:0] act_v;
      string         nm;
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      act_v = {is_invalid, x_cord, y_cord, epa};
      n_vectors++;
      if (act_v !== exp_v) begin
        n_miscompares++;
        $display("FAIL %s: got inv=%0b x=%h y=%h epa=%h, want inv=%0b x=%h y=%h epa=%h",
                 nm, act_v[RW-1], act_v[RW-2 -: XW], act_v[AW+YW-1 -: YW], act_v[AW-1:0],
                 exp_v[RW-1], exp_v[RW-2 -: XW], exp_v[AW+YW-1 -: YW], exp_v[AW-1:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_vectors     = 0;
    n_miscompares = 0;
    reset = 1'b1;
    eva   = 32'h0000_1000;
    tgo_x = '0;
    tgo_y = '0;
    pod_x = 3'd1;
    pod_y = 4'd1;

    // Outputs follow inputs even while reset is held.
    apply("reset_local",   1'b1, 32'h0000_1000, 4'd0, 3'd0, 3'd1, 4'd1, 1'b1, 7'h00, 7'h00, 28'h0);
    apply("reset_dram",    1'b1, 32'h8000_0020, 4'd0, 3'd0, 3'd1, 4'd1, 1'b0, 7'h11, 7'h07, 28'h0);
    apply("dram_north",    1'b0, 32'h8000_0020, 4'd0, 3'd0, 3'd1, 4'd1, 1'b0, 7'h11, 7'h07, 28'h0);
    apply("dram_south",    1'b0, 32'h8000_0200, 4'd0, 3'd0, 3'd1, 4'd1, 1'b0, 7'h10, 7'h10, 28'h0);
    apply("dram_offset",   1'b0, 32'h8000_0404, 4'd0, 3'd0, 3'd1, 4'd1, 1'b0, 7'h10, 7'h07, 28'h9);
    apply("dram_ones",     1'b0, 32'hFFFF_FFFF, 4'd0, 3'd0, 3'd1, 4'd1, 1'b0, 7'h1F, 7'h10, 28'hFF_FFFF);
    apply("dram_ywrap_n",  1'b0, 32'h8000_0020, 4'd0, 3'd0, 3'd1, 4'd0, 1'b0, 7'h11, 7'h7F, 28'h0);
    apply("dram_ywrap_s",  1'b0, 32'h8000_0200, 4'd0, 3'd0, 3'd1, 4'd15, 1'b0, 7'h10, 7'h00, 28'h0);
    apply("dram_podx5",    1'b0, 32'h8000_0020, 4'd0, 3'd0, 3'd5, 4'd1, 1'b0, 7'h51, 7'h07, 28'h0);
    apply("global",        1'b0, 32'h4925_0010, 4'd0, 3'd0, 3'd1, 4'd1, 1'b0, 7'h25, 7'h12, 28'h4);
    apply("global_ones",   1'b0, 32'h7FFF_FFFF, 4'd0, 3'd0, 3'd1, 4'd1, 1'b0, 7'h7F, 7'h7F, 28'h3FFF);
    apply("global_base",   1'b0, 32'h4000_0000, 4'd0, 3'd0, 3'd1, 4'd1, 1'b0, 7'h00, 7'h00, 28'h0);
    apply("tg_wrap",       1'b0, 32'h2CC0_0008, 4'd14, 3'd6, 3'd1, 4'd1, 1'b0, 7'h11, 7'h09, 28'h2);
    apply("tg_plain",      1'b0, 32'h2000_0004, 4'd0, 3'd0, 3'd1, 4'd1, 1'b0, 7'h10, 7'h08, 28'h1);
    apply("tg_ones",       1'b0, 32'h3FFF_FFFF, 4'd14, 3'd6, 3'd1, 4'd1, 1'b0, 7'h1D, 7'h0D, 28'hF_FFFF);
    apply("tg_base",       1'b0, 32'h2000_0000, 4'd14, 3'd6, 3'd1, 4'd1, 1'b0, 7'h1E, 7'h0E, 28'h0);
    apply("local",         1'b0, 32'h0000_1000, 4'd0, 3'd0, 3'd1, 4'd1, 1'b1, 7'h00, 7'h00, 28'h0);
    apply("local_top",     1'b0, 32'h1FFF_FFFF, 4'd5, 3'd3, 3'd1, 4'd1, 1'b1, 7'h00, 7'h00, 28'h0);
    apply("local_reset",   1'b1, 32'h0000_1000, 4'd0, 3'd0, 3'd1, 4'd1, 1'b1, 7'h00, 7'h00, 28'h0);
    apply("local_release", 1'b0, 32'h0000_1000, 4'd0, 3'd0, 3'd1, 4'd1, 1'b1, 7'h00, 7'h00, 28'h0);

    // Drain: the monitor needs one negedge per pushed vector.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_miscompares++;
      $display("FAIL drain: %0d expected responses left unchecked, want 0", exp_q.size());
    end
    if (n_vectors != 20) begin
      n_miscompares++;
      $display("FAIL vector_count: checked %0d, want 20", n_vectors);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
